// File: rtl/adder_acc_win.sv
// Windowed accumulator: sums WINDOW unsigned samples and pulses oValid with the total.
// Optional saturation with a sticky overflow flag is enabled by defining ADDER_ACC_SAT_EN.
module adder_acc_win #(
    parameter int BITWIDTH = 32,
    parameter int WINDOW   = 16,
    parameter int ACCWIDTH = BITWIDTH + 1 + $clog2(WINDOW),
    parameter int CNTWIDTH = $clog2(WINDOW)
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH:0]   iData,
    output logic [ACCWIDTH-1:0] oData,
    output logic                oValid,
    output logic [CNTWIDTH-1:0] oCount,
    output logic                oOvf
);

    logic [ACCWIDTH-1:0] acc_q, acc_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;
    logic [ACCWIDTH-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic [ACCWIDTH-1:0] sum_res;
    logic                sum_ovf;
    logic                last_sample;

    assign last_sample = (cnt_q == CNTWIDTH'(WINDOW - 1));

`ifdef ADDER_ACC_SAT_EN
    // Wide enough for the carry-out even when the sample is wider than the accumulator.
    localparam int SUMW = ((ACCWIDTH > BITWIDTH + 1) ? ACCWIDTH : BITWIDTH + 1) + 1;

    logic [SUMW-1:0] sum_wide;
    logic            ovf_q, ovf_d;

    assign sum_wide = SUMW'(acc_q) + SUMW'(iData);
    assign sum_ovf  = |sum_wide[SUMW-1:ACCWIDTH];
    assign sum_res  = sum_ovf ? {ACCWIDTH{1'b1}} : sum_wide[ACCWIDTH-1:0];
    assign oOvf     = ovf_q;
`else
    assign sum_res = acc_q + ACCWIDTH'(iData);
    assign sum_ovf = 1'b0;
    assign oOvf    = 1'b0;
`endif

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef ADDER_ACC_SAT_EN
        ovf_d   = ovf_q;
`endif
        if (iClr) begin
            // The sample presented with a clear is dropped; the last total stays visible.
            acc_d = '0;
            cnt_d = '0;
        end else if (iEn) begin
            if (last_sample) begin
                data_d  = sum_res;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum_res;
                cnt_d = cnt_q + CNTWIDTH'(1);
            end
`ifdef ADDER_ACC_SAT_EN
            if (sum_ovf) begin
                ovf_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef ADDER_ACC_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef ADDER_ACC_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign oData  = data_q;
    assign oValid = valid_q;
    assign oCount = cnt_q;

endmodule

// File: tb/tb_adder_acc_win.sv
// Directed bench for adder_acc_win: BITWIDTH=8, WINDOW=4, plus a narrow ACCWIDTH=9 copy
// used for the overflow scenario.
module tb_adder_acc_win;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [8:0]  din;
    logic [10:0] o_data;
    logic        o_valid;
    logic [1:0]  o_count;
    logic        o_ovf;
    logic [8:0]  n_data;
    logic        n_valid;
    logic [1:0]  n_count;
    logic        n_ovf;

    int checks = 0;
    int errors = 0;

    adder_acc_win #(.BITWIDTH(8), .WINDOW(4)) dut (
        .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iData(din),
        .oData(o_data), .oValid(o_valid), .oCount(o_count), .oOvf(o_ovf)
    );

    adder_acc_win #(.BITWIDTH(8), .WINDOW(4), .ACCWIDTH(9)) dut_n (
        .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iData(din),
        .oData(n_data), .oValid(n_valid), .oCount(n_count), .oOvf(n_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one edge worth of inputs, then settle past the edge before sampling.
    task automatic drive(input logic rst_v, input logic en_v, input logic clr_v, input int d);
        rst_n = rst_v;
        en    = en_v;
        clr   = clr_v;
        din   = 9'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b0, 5);
        checks++;
        if (o_data !== 11'd0 || o_valid !== 1'b0 || o_count !== 2'd0 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset data=%0d valid=%0b count=%0d ovf=%0b want 0 0 0 0",
                     o_data, o_valid, o_count, o_ovf);
        end
    endtask

    task automatic test_basic();
        int           exp_cnt [4] = '{1, 2, 3, 0};
        logic         exp_val [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, i + 1);
            checks++;
            if (o_count !== 2'(exp_cnt[i]) || o_valid !== exp_val[i]) begin
                errors++;
                $display("FAIL basic_step%0d count=%0d valid=%0b want %0d %0b",
                         i, o_count, o_valid, exp_cnt[i], exp_val[i]);
            end
        end
        checks++;
        if (o_data !== 11'd10) begin
            errors++;
            $display("FAIL basic_total got %0d want 10", o_data);
        end
        drive(1'b1, 1'b0, 1'b0, 0);
        checks++;
        if (o_valid !== 1'b0 || o_data !== 11'd10) begin
            errors++;
            $display("FAIL basic_pulse_width valid=%0b data=%0d want 0 10", o_valid, o_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 511);
            checks++;
            if (o_valid !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL b2b_valid cycle %0d got %0b want %0b", i, o_valid, (i % 4) == 0);
            end
            if ((i % 4) == 0) begin
                checks++;
                if (o_data !== 11'd2044) begin
                    errors++;
                    $display("FAIL b2b_total cycle %0d got %0d want 2044", i, o_data);
                end
            end
        end
    endtask

    task automatic test_gap();
        drive(1'b1, 1'b1, 1'b0, 5);
        drive(1'b1, 1'b1, 1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 77);
            checks++;
            if (o_count !== 2'd2 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold idle %0d count=%0d valid=%0b want 2 0", i, o_count, o_valid);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 5);
        drive(1'b1, 1'b1, 1'b0, 5);
        checks++;
        if (o_data !== 11'd20 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_total data=%0d valid=%0b want 20 1", o_data, o_valid);
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 1'b0, 30);
        drive(1'b1, 1'b1, 1'b1, 99);
        checks++;
        if (o_count !== 2'd0 || o_data !== 11'd20 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear count=%0d data=%0d valid=%0b want 0 20 0", o_count, o_data, o_valid);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1);
        checks++;
        if (o_data !== 11'd4 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_next data=%0d valid=%0b want 4 1", o_data, o_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 3);
        checks++;
        if (o_data !== 11'd0 || o_count !== 2'd0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid data=%0d count=%0d valid=%0b want 0 0 0", o_data, o_count, o_valid);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 7);
        checks++;
        if (o_data !== 11'd28 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_next data=%0d valid=%0b want 28 1", o_data, o_valid);
        end
    endtask

    task automatic test_overflow();
        logic [8:0] exp_data;
        logic       exp_ovf;
`ifdef ADDER_ACC_SAT_EN
        exp_data = 9'd511;
        exp_ovf  = 1'b1;
`else
        exp_data = 9'd90;
        exp_ovf  = 1'b0;
`endif
        drive(1'b0, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 300);
        drive(1'b1, 1'b1, 1'b0, 300);
        drive(1'b1, 1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b0, 1);
        checks++;
        if (n_data !== exp_data || n_ovf !== exp_ovf || n_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_narrow data=%0d ovf=%0b valid=%0b want %0d %0b 1",
                     n_data, n_ovf, n_valid, exp_data, exp_ovf);
        end
        checks++;
        if (o_data !== 11'd602 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_wide data=%0d ovf=%0b want 602 0", o_data, o_ovf);
        end
        drive(1'b1, 1'b1, 1'b1, 0);
        checks++;
        if (n_ovf !== exp_ovf || n_data !== exp_data) begin
            errors++;
            $display("FAIL ovf_after_clear ovf=%0b data=%0d want %0b %0d", n_ovf, n_data, exp_ovf, exp_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        din   = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_gap();
        test_clear();
        test_reset_mid();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_acc_win.md
Name: adder_acc_win

Overview:
- Windowed accumulator that sits directly downstream of the registered adder stage.
- Consumes the adder's BITWIDTH+1-bit sum stream, one sample per enabled cycle.
- Accumulates exactly WINDOW samples, then presents the window total with a one-cycle valid pulse.
- Restarts the next window with no bubble. Used for block sums and dot-product partial reduction.

Parameters:
BITWIDTH, 32, operand width of the upstream adder; input sample width is BITWIDTH+1
WINDOW, 16, samples per window; integer >= 2 (not required to be a power of two)
ACCWIDTH, BITWIDTH+1+$clog2(WINDOW), accumulator and output width; may be set smaller, overflow is then handled per Optional Feature
CNTWIDTH, $clog2(WINDOW), width of sample counter (derived, not to be overridden)

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  synchronous active-low reset
iEn  input  1  sample qualifier; iData is accumulated on a rising edge where iEn=1
iClr  input  1  synchronous clear of the window in progress
iData  input  BITWIDTH+1  unsigned sum from the upstream adder
oData  output  ACCWIDTH  window total; holds last completed total
oValid  output  1  one-cycle pulse: oData updated this cycle
oCount  output  CNTWIDTH  samples accumulated in the current window (0..WINDOW-1)
oOvf  output  1  sticky overflow flag (only meaningful with ADDER_ACC_SAT_EN; tied 0 otherwise)

Behaviour:
- Reset: synchronous. Edge with iRstN=0 sets acc=0, cnt=0, oData=0, oValid=0, oCount=0, oOvf=0.
- Reset mid-window discards the partial sum. No output pulse is produced.
- Internal state: acc (ACCWIDTH), cnt (CNTWIDTH). Phase is fully defined by cnt; there is no separate FSM register.
  - ACC phase: cnt = 0..WINDOW-2.
  - LAST phase: cnt = WINDOW-1.
- Priority per edge: iRstN=0 > iClr=1 > iEn=1 > hold.
- iClr=1 with iRstN=1:
  - acc=0, cnt=0, oValid=0.
  - oData and oOvf are retained.
  - The iData sample on that edge is dropped, even if iEn=1.
- iEn=1, cnt<WINDOW-1: acc<=acc+iData (zero-extended), cnt<=cnt+1, oValid<=0.
- iEn=1, cnt==WINDOW-1 (window completes):
  - oData<=acc+iData.
  - oValid<=1.
  - acc<=0, cnt<=0.
  - Next window starts on the following enabled edge. Back-to-back windows: total every WINDOW enabled cycles, no idle cycle.
- iEn=0: acc, cnt, oData hold; oValid<=0. Gaps in iEn stretch the window but never change the sample count.
- Latency: the total appears at Q of the same edge that samples the last input. The window total is therefore visible one cycle after the last sample is presented, matching the upstream adder's one-cycle register latency.
- oValid never asserts for two consecutive cycles, except when WINDOW samples complete on consecutive edges. That is impossible for WINDOW>=2, so oValid is always a single-cycle pulse.
- oCount = cnt (registered, no combinational path).
- Arithmetic is unsigned.
  - Default ACCWIDTH cannot overflow: max total = WINDOW*(2^(BITWIDTH+1)-1).
  - With a reduced ACCWIDTH and no macro, the sum wraps modulo 2^ACCWIDTH.

Optional Feature:
- Macro: ADDER_ACC_SAT_EN.
- Defined:
  - Each addition is computed at ACCWIDTH+1 bits.
  - If the carry-out is set, acc (or oData on the completing edge) saturates to 2^ACCWIDTH-1.
  - Once saturated, acc stays saturated for the rest of that window.
  - oOvf<=1 on the edge a saturation occurs. oOvf is sticky until reset only; iClr does not clear it.
- Not defined:
  - Modulo wrap-around.
  - oOvf is constant 0 and no saturation logic is synthesized.

Test Plan:
- Bench config for all scenarios below: BITWIDTH=8, WINDOW=4, default ACCWIDTH=11.
- Reset then iEn=1, iData=1,2,3,4 on consecutive edges -> oValid pulses once, on the edge sampling 4; oData=10; oCount sequence 1,2,3,0.
- Continuous iEn=1 with 8 samples of 511 -> two oValid pulses exactly 4 cycles apart, each oData=2044; no gap cycle between windows.
- iData=5,5 then iEn=0 for 3 cycles then 5,5 -> oCount holds 2 during gap; oData=20 after the 4th enabled sample; oValid low during gap.
- After 3 samples (10,20,30), assert iClr with iEn=1, iData=99 -> oCount=0, previous oData retained, no pulse; then 1,1,1,1 -> oData=4.
- iRstN=0 for one edge mid-window after 2 samples -> oData=0, oCount=0, oValid=0; next 4 samples of 7 -> oData=28.
- ADDER_ACC_SAT_EN, override ACCWIDTH=9, samples 300,300,1,1 -> oData=511, oOvf=1 and remains 1 through a subsequent iClr. Without the macro, the same stimulus gives oData=602 mod 512=90 and oOvf=0.
